pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised next-generation program counter with fetch control. Selects next PC from
//  sequential/branch/jump/JALR/trap sources. Holds on stall and inserts a bubble after
//  every redirect. Sits at the head of the fetch stage and drives instruction-memory address.
// PARAMETERS
//  PC_WIDTH      32            PC/address width
//  RESET_VECTOR  32'hBFC00000  PC loaded on reset (instruction memory base)
//  TRAP_VECTOR   32'hBFC00180  PC loaded on misaligned-target trap (PC_MISALIGN_TRAP_EN only)
//  CNT_WIDTH     32            width of fetch counter
// PORTS
//  clk             in   1         clock, rising edge
//  rst             in   1         synchronous, active-high reset
//  stall           in   1         hold PC and fetch_valid (hazard unit)
//  redirect        in   1         resolved control transfer this cycle
//  redirect_kind   in   2         pc_kind_t: BRANCH, JAL, JALR
//  redirect_target in   PC_WIDTH  computed target (JALR: rs1+imm, unmasked)
//  halt            in   1         stop fetching (ebreak/ecall)
//  resume          in   1         leave HALT
//  pc              out  PC_WIDTH  current fetch address
//  pc_plus4        out  PC_WIDTH  pc + 4, for link register
//  fetch_valid     out  1         instruction at pc is valid for decode
//  misalign_trap   out  1         1-cycle pulse, target not 4-byte aligned
//  fetch_count     out  CNT_WIDTH accepted fetches since reset
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, fetch_valid=0, misalign_trap=0, fetch_count=0, state=BOOT.
//  - FSM pc_state_t: BOOT -> RUN unconditionally after one cycle (memory read latency fill).
//    RUN: fetch_valid=1 unless stall. On redirect -> BUBBLE. On halt -> HALT.
//    BUBBLE: one cycle, fetch_valid=0, pc already at target; then -> RUN (stall extends BUBBLE).
//    HALT: pc held, fetch_valid=0; resume -> RUN with pc unchanged.
//  - Next-PC priority per cycle: rst > halt > redirect > stall > pc+4.
//  - Redirect overrides stall (wrong-path instruction must be discarded).
//  - JALR target: bit 0 forced to 0 before use. BRANCH/JAL: target used as-is.
//  - Misalignment check: target[1] after masking. Response is set by PC_MISALIGN_TRAP_EN.
//  - redirect and halt in the same cycle: halt wins, redirect dropped, pc held.
//  - redirect in BOOT is ignored. redirect in HALT is ignored.
//  - pc+4 wraps modulo 2^PC_WIDTH. No saturation.
//  - fetch_count increments when fetch_valid && !stall. It wraps at 2^CNT_WIDTH.
//  - pc_plus4 is combinational from pc. All other outputs are registered.
//  - rst asserted in any state returns to BOOT next edge. The pending redirect is lost.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//    - Misaligned redirect loads TRAP_VECTOR instead of target.
//    - misalign_trap pulses for 1 cycle.
//    - FSM goes to BUBBLE.
//  Undefined:
//    - target[1:0] is forced to 2'b00.
//    - misalign_trap is tied 0.
//    - TRAP_VECTOR is unused.
// STRUCTURE
//  pc_pkg:
//    - typedef enum logic[1:0] pc_kind_t {PC_BRANCH, PC_JAL, PC_JALR}
//    - typedef enum logic[1:0] pc_state_t {PC_BOOT, PC_RUN, PC_BUBBLE, PC_HALT}
//    - localparam PC_INC = 4
//  Sub-module pc_target_sel (combinational):
//    - JALR masking, alignment check, trap substitution
//    - outputs next_target and misaligned
//  Top holds FSM, PC register, and counter.
// TESTING
//  1. rst 3 cycles, release:
//     - cycle0 pc=BFC00000, fetch_valid=0
//     - cycle1 fetch_valid=1
//     - cycle2 pc=BFC00004
//  2. RUN at BFC00010, redirect BRANCH target BFC00100:
//     - next pc=BFC00100, fetch_valid=0 one cycle
//     - then BFC00104 valid
//  3. stall 3 cycles at BFC00008:
//     - pc, fetch_count frozen
//     - redirect during stall still loads target
//  4. JALR target BFC00203:
//     - pc=BFC00202 trap-off -> BFC00200
//     - trap-on -> BFC00180 and misalign_trap=1 one cycle
//  5. halt+redirect same cycle: pc held, HALT. resume: pc continues +4 from held value.
//  6. pc=FFFFFFFC, no redirect: next pc=00000000. fetch_count wrap with CNT_WIDTH=4 after 16 fetches.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC controller.
// The PC_MISALIGN_TRAP_EN macro selects trap-on-misaligned-target instead of silent alignment.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BRANCH = 2'd0,
    PC_JAL    = 2'd1,
    PC_JALR   = 2'd2
  } pc_kind_t;

  typedef enum logic [1:0] {
    PC_BOOT   = 2'd0,
    PC_RUN    = 2'd1,
    PC_BUBBLE = 2'd2,
    PC_HALT   = 2'd3
  } pc_state_t;

  localparam int unsigned PC_INC = 4;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP_EN = 1'b1;
`else
  localparam bit MISALIGN_TRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target conditioning: JALR bit-0 clear, word-alignment check, trap substitution.
// Behaviour depends on PC_MISALIGN_TRAP_EN (via pc_pkg::MISALIGN_TRAP_EN).
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR = 32'hBFC00180
) (
  input  pc_kind_t                 redirect_kind,
  input  logic [PC_WIDTH-1:0]      redirect_target,
  output logic [PC_WIDTH-1:0]      next_target,
  output logic                     misaligned
);

  logic [PC_WIDTH-1:0] masked;

  always_comb begin
    masked = redirect_target;
    if (redirect_kind == PC_JALR) masked[0] = 1'b0;

    // Without the trap, misalignment is never reported; the low bits are simply dropped.
    misaligned = MISALIGN_TRAP_EN && masked[1];

    if (misaligned) begin
      next_target = TRAP_VECTOR;
    end else if (!MISALIGN_TRAP_EN) begin
      next_target = {masked[PC_WIDTH-1:2], 2'b00};
    end else begin
      next_target = masked;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator: boot fill, redirect bubble, stall hold, halt/resume, fetch counter.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 32'hBFC00180,
  parameter int unsigned         CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [1:0]           redirect_kind,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  input  logic                 halt,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic                 fetch_valid,
  output logic                 misalign_trap,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  pc_state_t            state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic                 misalign_trap_q, misalign_trap_d;
  logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic [PC_WIDTH-1:0]  next_target;
  logic                 misaligned;

  pc_target_sel #(
    .PC_WIDTH    (PC_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target_sel (
    .redirect_kind   (pc_kind_t'(redirect_kind)),
    .redirect_target (redirect_target),
    .next_target     (next_target),
    .misaligned      (misaligned)
  );

  assign pc_plus4 = pc_q + PC_WIDTH'(PC_INC);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fetch_valid_d   = fetch_valid_q;
    misalign_trap_d = 1'b0;
    fetch_count_d   = (fetch_valid_q && !stall) ? fetch_count_q + CNT_WIDTH'(1) : fetch_count_q;

    case (state_q)
      // Instruction memory needs one cycle to return the word at the reset vector.
      PC_BOOT: begin
        state_d       = PC_RUN;
        fetch_valid_d = 1'b1;
      end
      PC_RUN: begin
        if (halt) begin
          state_d       = PC_HALT;
          fetch_valid_d = 1'b0;
        end else if (redirect) begin
          state_d         = PC_BUBBLE;
          pc_d            = next_target;
          fetch_valid_d   = 1'b0;
          misalign_trap_d = misaligned;
        end else if (!stall) begin
          pc_d          = pc_plus4;
          fetch_valid_d = 1'b1;
        end
      end
      PC_BUBBLE: begin
        if (halt) begin
          state_d       = PC_HALT;
          fetch_valid_d = 1'b0;
        end else if (redirect) begin
          pc_d            = next_target;
          fetch_valid_d   = 1'b0;
          misalign_trap_d = misaligned;
        end else if (!stall) begin
          state_d       = PC_RUN;
          fetch_valid_d = 1'b1;
        end
      end
      PC_HALT: begin
        fetch_valid_d = 1'b0;
        if (resume && !halt) begin
          state_d       = PC_RUN;
          fetch_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = PC_BOOT;
        pc_d          = RESET_VECTOR;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= PC_BOOT;
      pc_q            <= RESET_VECTOR;
      fetch_valid_q   <= 1'b0;
      misalign_trap_q <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_valid_q   <= fetch_valid_d;
      misalign_trap_q <= misalign_trap_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign pc            = pc_q;
  assign fetch_valid   = fetch_valid_q;
  assign misalign_trap = misalign_trap_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a 4-bit fetch counter to exercise wrap-around.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined for the build.
module tb_pc_fetch_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [1:0] K_BRANCH = 2'd0;
  localparam logic [1:0] K_JAL    = 2'd1;
  localparam logic [1:0] K_JALR   = 2'd2;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] JALR_MIS_PC = 32'hBFC00180;
  localparam logic [31:0] TRAP_EXP    = 32'd1;
`else
  localparam logic [31:0] JALR_MIS_PC = 32'hBFC00200;
  localparam logic [31:0] TRAP_EXP    = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [1:0]    redirect_kind;
  logic [31:0]   redirect_target;
  logic          halt;
  logic          resume;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          fetch_valid;
  logic          misalign_trap;
  logic [CW-1:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (32'hBFC00000),
    .TRAP_VECTOR  (32'hBFC00180),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .halt            (halt),
    .resume          (resume),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_valid     (fetch_valid),
    .misalign_trap   (misalign_trap),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [31:0] e_pc, input logic e_fv,
                           input logic [31:0] e_cnt);
    check_val({tag, ".pc"}, pc, e_pc);
    check_val({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    check_val({tag, ".cnt"}, {28'd0, fetch_count}, e_cnt);
  endtask

  task automatic set_redirect(input logic [1:0] kind, input logic [31:0] tgt);
    redirect        = 1'b1;
    redirect_kind   = kind;
    redirect_target = tgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_kind = K_BRANCH;
    redirect_target = '0; halt = 1'b0; resume = 1'b0;

    // 1. reset and boot
    repeat (3) step();
    rst = 1'b0;
    expect_st("rst", 32'hBFC00000, 1'b0, 0);
    check_val("rst.trap", {31'd0, misalign_trap}, 32'd0);
    step(); expect_st("boot1", 32'hBFC00000, 1'b1, 0);
    step(); expect_st("boot2", 32'hBFC00004, 1'b1, 1);
    check_val("boot2.plus4", pc_plus4, 32'hBFC00008);
    repeat (3) step();
    expect_st("run010", 32'hBFC00010, 1'b1, 4);

    // 2. branch redirect with bubble
    set_redirect(K_BRANCH, 32'hBFC00100);
    step(); redirect = 1'b0;
    expect_st("br.bub", 32'hBFC00100, 1'b0, 5);
    step(); expect_st("br.tgt", 32'hBFC00100, 1'b1, 5);
    step(); expect_st("br.seq", 32'hBFC00104, 1'b1, 6);

    // 3. stall at BFC00008, redirect overrides stall
    set_redirect(K_JAL, 32'hBFC00008);
    step(); redirect = 1'b0;
    step(); expect_st("st.pre", 32'hBFC00008, 1'b1, 7);
    stall = 1'b1;
    repeat (3) step();
    expect_st("st.hold", 32'hBFC00008, 1'b1, 7);
    set_redirect(K_BRANCH, 32'hBFC00300);
    step(); redirect = 1'b0; stall = 1'b0;
    expect_st("st.redir", 32'hBFC00300, 1'b0, 7);
    step(); expect_st("st.run", 32'hBFC00300, 1'b1, 7);

    // 4. JALR misaligned target
    set_redirect(K_JALR, 32'hBFC00203);
    step(); redirect = 1'b0;
    expect_st("jalr.mis", JALR_MIS_PC, 1'b0, 8);
    check_val("jalr.trap", {31'd0, misalign_trap}, TRAP_EXP);
    step();
    check_val("jalr.trap1", {31'd0, misalign_trap}, 32'd0);
    expect_st("jalr.run", JALR_MIS_PC, 1'b1, 8);
    set_redirect(K_JALR, 32'hBFC00401);
    step(); redirect = 1'b0;
    expect_st("jalr.b0", 32'hBFC00400, 1'b0, 9);
    check_val("jalr.b0trap", {31'd0, misalign_trap}, 32'd0);
    step(); expect_st("jalr.b0run", 32'hBFC00400, 1'b1, 9);

    // 5. halt beats redirect, redirect ignored in HALT, resume
    halt = 1'b1; set_redirect(K_BRANCH, 32'hBFC00500);
    step(); halt = 1'b0; redirect = 1'b0;
    expect_st("halt", 32'hBFC00400, 1'b0, 10);
    step(); expect_st("halt.hold", 32'hBFC00400, 1'b0, 10);
    set_redirect(K_JAL, 32'hBFC00600);
    step(); redirect = 1'b0;
    expect_st("halt.redir", 32'hBFC00400, 1'b0, 10);
    resume = 1'b1;
    step(); resume = 1'b0;
    expect_st("resume", 32'hBFC00400, 1'b1, 10);
    step(); expect_st("resume.seq", 32'hBFC00404, 1'b1, 11);

    // 6. PC wrap and counter wrap
    set_redirect(K_JAL, 32'hFFFFFFFC);
    step(); redirect = 1'b0;
    step(); expect_st("wrap.top", 32'hFFFFFFFC, 1'b1, 12);
    check_val("wrap.plus4", pc_plus4, 32'h00000000);
    step(); expect_st("wrap.zero", 32'h00000000, 1'b1, 13);
    repeat (3) step();
    expect_st("cnt.wrap", 32'h0000000C, 1'b1, 0);

    // reset drops a pending redirect; redirect in BOOT is ignored
    rst = 1'b1; set_redirect(K_BRANCH, 32'hBFC00700);
    step(); rst = 1'b0;
    expect_st("rst2", 32'hBFC00000, 1'b0, 0);
    step(); redirect = 1'b0;
    expect_st("boot.redir", 32'hBFC00000, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
